// File: rtl/chi_link_act_ctrl.sv
// chi_link_act_ctrl: CHI link-layer controller for one port pair.
// Runs the Tx activation/deactivation handshake and the Rx response handshake,
// tracks L-credits in both directions and round-robins the Tx link between
// NUM_REQ local flit requesters. Every output comes straight from a flop.
module chi_link_act_ctrl #(
   parameter int NUM_REQ      = 4,
   parameter int MAX_TX_CRD   = 15,
   parameter int MAX_RX_CRD   = 15,
   parameter int IDLE_TIMEOUT = 16
) (
   input  logic               ACLK,
   input  logic               ARESET,
   input  logic               link_en,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic               txlinkactivereq,
   input  logic               txlinkactiveack,
   input  logic               txlcrdv,
   output logic               tx_crd_ret,
   input  logic               rxlinkactivereq,
   output logic               rxlinkactiveack,
   output logic               rxlcrdv,
   input  logic               rxflitv,
   output logic [1:0]         tx_state,
   output logic [1:0]         rx_state,
   output logic               proto_err
);

   localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TXC_W  = $clog2(MAX_TX_CRD + 1);
   localparam int RXC_W  = $clog2(MAX_RX_CRD + 1);
   localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

   localparam logic [TXC_W-1:0]  TX_CRD_MAX = TXC_W'(MAX_TX_CRD);
   localparam logic [RXC_W-1:0]  RX_CRD_MAX = RXC_W'(MAX_RX_CRD);
   localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(IDLE_TIMEOUT);

   typedef enum logic [1:0] {
      ST_STOP  = 2'd0,
      ST_ACT   = 2'd1,
      ST_RUN   = 2'd2,
      ST_DEACT = 2'd3
   } link_state_e;

   link_state_e        tx_state_q, tx_state_d;
   link_state_e        rx_state_q, rx_state_d;
   logic [IDLE_W-1:0]  idle_q, idle_d;
   logic [TXC_W-1:0]   tx_crd_q, tx_crd_d;
   logic [RXC_W-1:0]   rx_out_q, rx_out_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic               txreq_q, txreq_d;
   logic               tx_crd_ret_q, tx_crd_ret_d;
   logic               rxack_q, rxack_d;
   logic               rxlcrdv_q, rxlcrdv_d;
   logic               proto_err_q, proto_err_d;

   logic               grant_ok;
   logic               found;
   int                 idx;
   logic [PTR_W-1:0]   sel;
   logic               tx_inc, tx_dec;
   logic               rx_inc, rx_dec;

   // Tx link FSM: activation handshake, idle timeout in Run, drain credits in Deact
   always_comb begin
      tx_state_d = tx_state_q;
      idle_d     = '0;
      case (tx_state_q)
         ST_STOP: begin
            if (link_en && (|req)) tx_state_d = ST_ACT;
         end
         ST_ACT: begin
            if (!link_en) tx_state_d = ST_DEACT;
            else if (txlinkactiveack) tx_state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!link_en || (idle_q == IDLE_LIMIT)) tx_state_d = ST_DEACT;
            else if (!(|req)) idle_d = idle_q + IDLE_W'(1);
         end
         ST_DEACT: begin
            if (!txlinkactiveack && (tx_crd_q == '0) && !txlcrdv) tx_state_d = ST_STOP;
         end
         default: tx_state_d = ST_STOP;
      endcase
      txreq_d = (tx_state_d == ST_ACT) || (tx_state_d == ST_RUN);
   end

   // Round-robin arbiter: search from ptr, grant the first requester, move ptr past it
   always_comb begin
      gnt_d    = '0;
      ptr_d    = ptr_q;
      found    = 1'b0;
      idx      = 0;
      sel      = '0;
      grant_ok = (tx_state_q == ST_RUN) && (tx_state_d == ST_RUN) && (tx_crd_q != '0);
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         sel = PTR_W'(idx);
         if (grant_ok && !found && req[sel]) begin
            found      = 1'b1;
            gnt_d[sel] = 1'b1;
            ptr_d      = (idx == NUM_REQ - 1) ? '0 : PTR_W'(idx + 1);
         end
      end
   end

   // Tx credit counter: receive on txlcrdv, spend on a grant or a credit-return flit
   always_comb begin
      tx_crd_ret_d = (tx_state_q == ST_DEACT) && (tx_crd_q != '0);
      tx_inc       = txlcrdv && (tx_state_q != ST_STOP) && (tx_crd_q != TX_CRD_MAX);
      tx_dec       = (|gnt_d) || tx_crd_ret_d;
      tx_crd_d     = tx_crd_q;
      if (tx_inc && !tx_dec) tx_crd_d = tx_crd_q + TXC_W'(1);
      else if (!tx_inc && tx_dec) tx_crd_d = tx_crd_q - TXC_W'(1);
   end

   // Rx link FSM and outstanding Rx credit counter
   always_comb begin
      rx_state_d = rx_state_q;
      case (rx_state_q)
         ST_STOP: begin
            if (rxlinkactivereq) rx_state_d = ST_ACT;
         end
         ST_ACT: begin
            rx_state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!rxlinkactivereq) rx_state_d = ST_DEACT;
         end
         ST_DEACT: begin
            if (rx_out_q == '0) rx_state_d = ST_STOP;
         end
         default: rx_state_d = ST_STOP;
      endcase
      rxack_d   = (rx_state_d != ST_STOP);
      rxlcrdv_d = (rx_state_q == ST_RUN) && rxlinkactivereq && (rx_out_q != RX_CRD_MAX);
      rx_inc    = rxlcrdv_d;
      rx_dec    = rxflitv && (rx_out_q != '0);
      rx_out_d  = rx_out_q;
      if (rx_inc && !rx_dec) rx_out_d = rx_out_q + RXC_W'(1);
      else if (!rx_inc && rx_dec) rx_out_d = rx_out_q - RXC_W'(1);
   end

   // Sticky protocol error: credit overflow, credit while stopped, flit with no credit out
   always_comb begin
      proto_err_d = proto_err_q;
      if (txlcrdv && ((tx_state_q == ST_STOP) || (tx_crd_q == TX_CRD_MAX))) proto_err_d = 1'b1;
      if (rxflitv && (rx_out_q == '0)) proto_err_d = 1'b1;
   end

   // State and output registers; reset aborts everything at once
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         tx_state_q   <= ST_STOP;
         rx_state_q   <= ST_STOP;
         idle_q       <= '0;
         tx_crd_q     <= '0;
         rx_out_q     <= '0;
         ptr_q        <= '0;
         gnt_q        <= '0;
         txreq_q      <= 1'b0;
         tx_crd_ret_q <= 1'b0;
         rxack_q      <= 1'b0;
         rxlcrdv_q    <= 1'b0;
         proto_err_q  <= 1'b0;
      end else begin
         tx_state_q   <= tx_state_d;
         rx_state_q   <= rx_state_d;
         idle_q       <= idle_d;
         tx_crd_q     <= tx_crd_d;
         rx_out_q     <= rx_out_d;
         ptr_q        <= ptr_d;
         gnt_q        <= gnt_d;
         txreq_q      <= txreq_d;
         tx_crd_ret_q <= tx_crd_ret_d;
         rxack_q      <= rxack_d;
         rxlcrdv_q    <= rxlcrdv_d;
         proto_err_q  <= proto_err_d;
      end
   end

   assign gnt             = gnt_q;
   assign txlinkactivereq = txreq_q;
   assign tx_crd_ret      = tx_crd_ret_q;
   assign rxlinkactiveack = rxack_q;
   assign rxlcrdv         = rxlcrdv_q;
   assign tx_state        = tx_state_q;
   assign rx_state        = rx_state_q;
   assign proto_err       = proto_err_q;

endmodule

// File: tb/tb_chi_link_act_ctrl.sv
// tb_chi_link_act_ctrl: directed scenarios for the CHI link activation controller.
module tb_chi_link_act_ctrl;

   logic       ACLK = 1'b0;
   logic       ARESET;
   logic       link_en;
   logic [3:0] req;
   logic [3:0] gnt;
   logic       txlinkactivereq;
   logic       txlinkactiveack;
   logic       txlcrdv;
   logic       tx_crd_ret;
   logic       rxlinkactivereq;
   logic       rxlinkactiveack;
   logic       rxlcrdv;
   logic       rxflitv;
   logic [1:0] tx_state;
   logic [1:0] rx_state;
   logic       proto_err;

   int total = 0;
   int bad   = 0;

   chi_link_act_ctrl #(
      .NUM_REQ(4), .MAX_TX_CRD(15), .MAX_RX_CRD(15), .IDLE_TIMEOUT(16)
   ) dut (
      .ACLK(ACLK), .ARESET(ARESET), .link_en(link_en), .req(req), .gnt(gnt),
      .txlinkactivereq(txlinkactivereq), .txlinkactiveack(txlinkactiveack),
      .txlcrdv(txlcrdv), .tx_crd_ret(tx_crd_ret),
      .rxlinkactivereq(rxlinkactivereq), .rxlinkactiveack(rxlinkactiveack),
      .rxlcrdv(rxlcrdv), .rxflitv(rxflitv),
      .tx_state(tx_state), .rx_state(rx_state), .proto_err(proto_err)
   );

   // free-running clock
   always #5 ACLK = ~ACLK;

   // one clock edge; outputs are then observed at the falling edge
   task automatic tick();
      @(posedge ACLK);
      @(negedge ACLK);
   endtask

   task automatic do_reset();
      ARESET = 1'b1; link_en = 1'b0; req = 4'b0000;
      txlinkactiveack = 1'b0; txlcrdv = 1'b0;
      rxlinkactivereq = 1'b0; rxflitv = 1'b0;
      tick(); tick();
      ARESET = 1'b0;
   endtask

   // Tx bring-up: req r_act wakes Stop->Act, then ack with r_run takes Act->Run
   task automatic tx_up(input logic [3:0] r_act, input logic [3:0] r_run);
      link_en = 1'b1; req = r_act;
      tick();
      req = r_run; txlinkactiveack = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if ({gnt, txlinkactivereq, tx_crd_ret, rxlinkactiveack, rxlcrdv, tx_state, rx_state, proto_err} !== 13'd0) begin
         bad++;
         $display("[TB] FAIL reset_outputs: got gnt=%b txreq=%b ret=%b rxack=%b rxlcrdv=%b txs=%0d rxs=%0d err=%b want all 0",
                  gnt, txlinkactivereq, tx_crd_ret, rxlinkactiveack, rxlcrdv, tx_state, rx_state, proto_err);
      end
   endtask

   task automatic test_basic_grant();
      int cnt;
      do_reset();
      link_en = 1'b1; req = 4'b0001;
      tick();
      total++;
      if (txlinkactivereq !== 1'b1 || tx_state !== 2'd1) begin
         bad++; $display("[TB] FAIL basic_act: got txreq=%b state=%0d want 1/1", txlinkactivereq, tx_state);
      end
      txlinkactiveack = 1'b1;
      tick();
      total++;
      if (tx_state !== 2'd2) begin
         bad++; $display("[TB] FAIL basic_run: got state=%0d want 2", tx_state);
      end
      cnt = 0;
      for (int i = 0; i < 9; i++) begin
         txlcrdv = (i < 3);
         tick();
         if (gnt !== 4'b0000) begin
            cnt++;
            total++;
            if (gnt !== 4'b0001) begin
               bad++; $display("[TB] FAIL basic_gnt_value: got %b want 0001", gnt);
            end
         end
      end
      txlcrdv = 1'b0;
      total++;
      if (cnt != 3 || gnt !== 4'b0000) begin
         bad++; $display("[TB] FAIL basic_gnt_count: got %0d last=%b want 3 last=0000", cnt, gnt);
      end
   endtask

   task automatic test_round_robin();
      int cnt;
      logic [3:0] exp_g;
      do_reset();
      tx_up(4'b1111, 4'b1111);
      total++;
      if (tx_state !== 2'd2) begin
         bad++; $display("[TB] FAIL rr_run: got state=%0d want 2", tx_state);
      end
      cnt = 0;
      for (int i = 0; i < 14; i++) begin
         txlcrdv = (i < 8);
         tick();
         if (gnt !== 4'b0000) begin
            exp_g = 4'b0001 << (cnt % 4);
            total++;
            if (gnt !== exp_g) begin
               bad++; $display("[TB] FAIL rr_order: grant %0d got %b want %b", cnt, gnt, exp_g);
            end
            cnt++;
         end
      end
      txlcrdv = 1'b0;
      total++;
      if (cnt != 8) begin
         bad++; $display("[TB] FAIL rr_count: got %0d want 8", cnt);
      end
   endtask

   task automatic test_idle_timeout();
      int rets;
      do_reset();
      tx_up(4'b0001, 4'b0000);
      for (int i = 0; i < 16; i++) begin
         txlcrdv = (i < 5);
         tick();
      end
      txlcrdv = 1'b0;
      total++;
      if (tx_state !== 2'd2 || gnt !== 4'b0000) begin
         bad++; $display("[TB] FAIL idle_still_run: got state=%0d gnt=%b want 2/0000", tx_state, gnt);
      end
      tick();
      total++;
      if (tx_state !== 2'd3 || txlinkactivereq !== 1'b0 || tx_crd_ret !== 1'b0) begin
         bad++; $display("[TB] FAIL idle_deact: got state=%0d txreq=%b ret=%b want 3/0/0", tx_state, txlinkactivereq, tx_crd_ret);
      end
      txlinkactiveack = 1'b0;
      rets = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (tx_crd_ret === 1'b1 && tx_state === 2'd3) rets++;
      end
      total++;
      if (rets != 5) begin
         bad++; $display("[TB] FAIL idle_returns: got %0d want 5", rets);
      end
      tick();
      total++;
      if (tx_state !== 2'd0 || tx_crd_ret !== 1'b0) begin
         bad++; $display("[TB] FAIL idle_stop: got state=%0d ret=%b want 0/0", tx_state, tx_crd_ret);
      end
   endtask

   task automatic test_link_drop();
      do_reset();
      link_en = 1'b1; req = 4'b0001;
      tick();
      req = 4'b0000; link_en = 1'b0;
      tick();
      total++;
      if (tx_state !== 2'd3 || txlinkactivereq !== 1'b0) begin
         bad++; $display("[TB] FAIL drop_deact: got state=%0d txreq=%b want 3/0", tx_state, txlinkactivereq);
      end
      tick();
      total++;
      if (tx_state !== 2'd0) begin
         bad++; $display("[TB] FAIL drop_stop: got state=%0d want 0", tx_state);
      end
   endtask

   task automatic test_rx_credits();
      int cnt;
      do_reset();
      rxlinkactivereq = 1'b1;
      tick();
      total++;
      if (rxlinkactiveack !== 1'b1 || rx_state !== 2'd1) begin
         bad++; $display("[TB] FAIL rx_ack: got ack=%b state=%0d want 1/1", rxlinkactiveack, rx_state);
      end
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (rxlcrdv === 1'b1) cnt++;
      end
      total++;
      if (cnt != 15 || rx_state !== 2'd2) begin
         bad++; $display("[TB] FAIL rx_initial_credits: got %0d state=%0d want 15/2", cnt, rx_state);
      end
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         rxflitv = (i < 3);
         tick();
         if (rxlcrdv === 1'b1) cnt++;
      end
      rxflitv = 1'b0;
      total++;
      if (cnt != 3) begin
         bad++; $display("[TB] FAIL rx_refill: got %0d want 3", cnt);
      end
      rxlinkactivereq = 1'b0;
      tick();
      total++;
      if (rx_state !== 2'd3 || rxlinkactiveack !== 1'b1 || rxlcrdv !== 1'b0) begin
         bad++; $display("[TB] FAIL rx_deact: got state=%0d ack=%b lcrdv=%b want 3/1/0", rx_state, rxlinkactiveack, rxlcrdv);
      end
      cnt = 0;
      for (int i = 0; i < 15; i++) begin
         rxflitv = 1'b1;
         tick();
         if (rxlcrdv === 1'b1) cnt++;
      end
      rxflitv = 1'b0;
      total++;
      if (cnt != 0 || rx_state !== 2'd3 || rxlinkactiveack !== 1'b1) begin
         bad++; $display("[TB] FAIL rx_drain: got lcrdv=%0d state=%0d ack=%b want 0/3/1", cnt, rx_state, rxlinkactiveack);
      end
      tick();
      total++;
      if (rx_state !== 2'd0 || rxlinkactiveack !== 1'b0 || proto_err !== 1'b0) begin
         bad++; $display("[TB] FAIL rx_stop: got state=%0d ack=%b err=%b want 0/0/0", rx_state, rxlinkactiveack, proto_err);
      end
   endtask

   task automatic test_proto_err();
      int cnt;
      do_reset();
      link_en = 1'b1; req = 4'b0001;
      tick();
      req = 4'b0000; txlcrdv = 1'b1;
      for (int i = 0; i < 15; i++) tick();
      total++;
      if (proto_err !== 1'b0 || tx_state !== 2'd1) begin
         bad++; $display("[TB] FAIL err_tx_15ok: got err=%b state=%0d want 0/1", proto_err, tx_state);
      end
      tick();
      txlcrdv = 1'b0;
      total++;
      if (proto_err !== 1'b1) begin
         bad++; $display("[TB] FAIL err_tx_overflow: got %b want 1", proto_err);
      end
      txlinkactiveack = 1'b1; req = 4'b1111;
      cnt = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (gnt !== 4'b0000) cnt++;
      end
      total++;
      if (cnt != 15 || proto_err !== 1'b1) begin
         bad++; $display("[TB] FAIL err_tx_held15: got grants=%0d err=%b want 15/1", cnt, proto_err);
      end
      do_reset();
      total++;
      if (proto_err !== 1'b0) begin
         bad++; $display("[TB] FAIL err_cleared: got %b want 0", proto_err);
      end
      rxflitv = 1'b1;
      tick();
      rxflitv = 1'b0;
      total++;
      if (proto_err !== 1'b1 || rx_state !== 2'd0) begin
         bad++; $display("[TB] FAIL err_rx_underflow: got err=%b state=%0d want 1/0", proto_err, rx_state);
      end
      rxlinkactivereq = 1'b1;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (rxlcrdv === 1'b1) cnt++;
      end
      rxlinkactivereq = 1'b0;
      total++;
      if (cnt != 15) begin
         bad++; $display("[TB] FAIL err_rx_out_zero: got credits=%0d want 15", cnt);
      end
   endtask

   task automatic test_reset_mid();
      int cnt;
      do_reset();
      rxlinkactivereq = 1'b1;
      tx_up(4'b0001, 4'b0000);
      for (int i = 0; i < 7; i++) begin
         txlcrdv = 1'b1;
         tick();
      end
      txlcrdv = 1'b0;
      total++;
      if (tx_state !== 2'd2 || rx_state !== 2'd2) begin
         bad++; $display("[TB] FAIL mid_setup: got txs=%0d rxs=%0d want 2/2", tx_state, rx_state);
      end
      ARESET = 1'b1; link_en = 1'b0; txlinkactiveack = 1'b0; rxlinkactivereq = 1'b0;
      tick();
      total++;
      if ({gnt, txlinkactivereq, tx_crd_ret, rxlinkactiveack, rxlcrdv, tx_state, rx_state, proto_err} !== 13'd0) begin
         bad++;
         $display("[TB] FAIL mid_reset_outputs: got gnt=%b txreq=%b ret=%b rxack=%b rxlcrdv=%b txs=%0d rxs=%0d err=%b want all 0",
                  gnt, txlinkactivereq, tx_crd_ret, rxlinkactiveack, rxlcrdv, tx_state, rx_state, proto_err);
      end
      ARESET = 1'b0;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (tx_crd_ret !== 1'b0 || tx_state !== 2'd0 || rx_state !== 2'd0) cnt++;
      end
      total++;
      if (cnt != 0) begin
         bad++; $display("[TB] FAIL mid_after_release: got %0d bad cycles want 0", cnt);
      end
      tx_up(4'b0001, 4'b0001);
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (gnt !== 4'b0000) cnt++;
      end
      req = 4'b0000;
      total++;
      if (cnt != 0 || tx_state !== 2'd2) begin
         bad++; $display("[TB] FAIL mid_crd_cleared: got grants=%0d state=%0d want 0/2", cnt, tx_state);
      end
   endtask

   initial begin
      test_reset();
      test_basic_grant();
      test_round_robin();
      test_idle_timeout();
      test_link_drop();
      test_rx_credits();
      test_proto_err();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
